// File: rtl/dadda_pkg.sv
// Shared types, widths and per-step byte-select/shift helpers for the sequential Dadda multiplier.
package dadda_pkg;

  localparam int unsigned HALF_W = 8;
  localparam int unsigned FULL_W = 16;
  localparam int unsigned PROD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic [1:0] step_t;

  localparam step_t STEP_LAST = 2'd3;

  // Operand pair captured on accept
  typedef struct packed {
    logic [FULL_W-1:0] a;
    logic [FULL_W-1:0] b;
  } operands_t;

  // Step order: lo*lo, lo*hi, hi*lo, hi*hi (bit1 picks a byte, bit0 picks b byte)
  function automatic logic a_hi_sel(input step_t s);
    return s[1];
  endfunction

  function automatic logic b_hi_sel(input step_t s);
    return s[0];
  endfunction

  // Zero-extend a partial product and align it to its byte weight
  function automatic logic [PROD_W-1:0] pp_place(input logic [FULL_W-1:0] pp, input step_t s);
    logic [PROD_W-1:0] ext;
    ext = PROD_W'(pp);
    case (s)
      2'd0:    return ext;
      2'd3:    return ext << FULL_W;
      default: return ext << HALF_W;
    endcase
  endfunction

endpackage

// File: rtl/dadda_8.sv
// Combinational 8x8 unsigned Dadda multiplier: AND array, Dadda reduction (6,4,3,2), final adder.
module dadda_8
  import dadda_pkg::*;
(
  input  logic [HALF_W-1:0] a_i,
  input  logic [HALF_W-1:0] b_i,
  output logic [FULL_W-1:0] p_c_o
);

  localparam int unsigned COLS   = FULL_W;
  localparam int unsigned MAXH   = HALF_W;
  localparam int unsigned CW     = $clog2(COLS);
  localparam int unsigned RW     = $clog2(MAXH);
  localparam int unsigned NSTAGE = 4;

  function automatic logic [1:0] ha(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  function automatic logic [1:0] csa_dadda(input logic x, input logic y, input logic z);
    return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
  endfunction

  // Dadda height targets, last stage first reduces to 6
  function automatic int unsigned stage_h(input int unsigned s);
    case (s)
      0:       return 6;
      1:       return 4;
      2:       return 3;
      default: return 2;
    endcase
  endfunction

  logic [FULL_W-1:0] row0_c;
  logic [FULL_W-1:0] row1_c;

  // Build the bit matrix and reduce each column to at most two bits with HA/CSA cells
  always_comb begin : reduce
    logic [MAXH-1:0] cur  [COLS];
    logic [MAXH-1:0] nxt  [COLS];
    int unsigned     cnt  [COLS];
    int unsigned     ncnt [COLS];
    int unsigned     idx;
    int unsigned     d;
    logic [1:0]      r;
    idx    = 0;
    d      = 0;
    r      = '0;
    row0_c = '0;
    row1_c = '0;
    for (int unsigned j = 0; j < COLS; j++) begin
      cur[CW'(j)]  = '0;
      nxt[CW'(j)]  = '0;
      cnt[CW'(j)]  = 0;
      ncnt[CW'(j)] = 0;
    end
    for (int unsigned i = 0; i < HALF_W; i++) begin
      for (int unsigned k = 0; k < HALF_W; k++) begin
        cur[CW'(i + k)][RW'(cnt[CW'(i + k)])] = a_i[RW'(i)] & b_i[RW'(k)];
        cnt[CW'(i + k)] = cnt[CW'(i + k)] + 1;
      end
    end
    for (int unsigned s = 0; s < NSTAGE; s++) begin
      d = stage_h(s);
      for (int unsigned j = 0; j < COLS; j++) begin
        nxt[CW'(j)]  = '0;
        ncnt[CW'(j)] = 0;
      end
      for (int unsigned j = 0; j < COLS; j++) begin
        idx = 0;
        for (int unsigned it = 0; it < MAXH; it++) begin
          if (cnt[CW'(j)] - idx + ncnt[CW'(j)] > d) begin
            if (cnt[CW'(j)] - idx + ncnt[CW'(j)] == d + 1) begin
              r   = ha(cur[CW'(j)][RW'(idx)], cur[CW'(j)][RW'(idx + 1)]);
              idx = idx + 2;
            end else begin
              r   = csa_dadda(cur[CW'(j)][RW'(idx)], cur[CW'(j)][RW'(idx + 1)],
                              cur[CW'(j)][RW'(idx + 2)]);
              idx = idx + 3;
            end
            nxt[CW'(j)][RW'(ncnt[CW'(j)])] = r[0];
            ncnt[CW'(j)] = ncnt[CW'(j)] + 1;
            if (j + 1 < COLS) begin
              nxt[CW'(j + 1)][RW'(ncnt[CW'(j + 1)])] = r[1];
              ncnt[CW'(j + 1)] = ncnt[CW'(j + 1)] + 1;
            end
          end
        end
        for (int unsigned t = 0; t < MAXH; t++) begin
          if (t >= idx && t < cnt[CW'(j)]) begin
            nxt[CW'(j)][RW'(ncnt[CW'(j)])] = cur[CW'(j)][RW'(t)];
            ncnt[CW'(j)] = ncnt[CW'(j)] + 1;
          end
        end
      end
      for (int unsigned j = 0; j < COLS; j++) begin
        cur[CW'(j)] = nxt[CW'(j)];
        cnt[CW'(j)] = ncnt[CW'(j)];
      end
    end
    for (int unsigned j = 0; j < COLS; j++) begin
      row0_c[CW'(j)] = cur[CW'(j)][0];
      row1_c[CW'(j)] = cur[CW'(j)][1];
    end
  end

  // Final carry-propagate adder; carries past bit 15 are always zero for 8x8
  assign p_c_o = row0_c + row1_c;

endmodule

// File: rtl/dadda_mul16_seq.sv
// Sequential 16x16 unsigned multiplier time-sharing one 8x8 Dadda array over four byte steps.
module dadda_mul16_seq
  import dadda_pkg::*;
#(
  parameter int unsigned HALF_W = 8,
  parameter bit          REG_PP = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [FULL_W-1:0]   a,
  input  logic [FULL_W-1:0]   b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PROD_W-1:0]   p,
  output logic                busy
);

  state_e             state_q, state_d;
  step_t              step_q, step_d;
  operands_t          ops_q, ops_d;
  logic [PROD_W-1:0]  acc_q, acc_d;
  logic [PROD_W-1:0]  p_q, p_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic [FULL_W-1:0]  pp_q, pp_d;
  step_t              pp_step_q, pp_step_d;
  logic               pp_vld_q, pp_vld_d;
  logic               drain_q, drain_d;

  logic [HALF_W-1:0]  mul_a_c;
  logic [HALF_W-1:0]  mul_b_c;
  logic [FULL_W-1:0]  pp_c;
  logic               accept_c;

  // Byte selection for the current issue step
  assign mul_a_c = a_hi_sel(step_q) ? ops_q.a[FULL_W-1:HALF_W] : ops_q.a[HALF_W-1:0];
  assign mul_b_c = b_hi_sel(step_q) ? ops_q.b[FULL_W-1:HALF_W] : ops_q.b[HALF_W-1:0];

  dadda_8 u_dadda_8 (
    .a_i   (mul_a_c),
    .b_i   (mul_b_c),
    .p_c_o (pp_c)
  );

  // Ready is combinational so a waiting result can hand over to a new operand pair in one cycle
  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);

  // Next-state, step sequencing, accumulation and output load
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    ops_d       = ops_q;
    acc_d       = acc_q;
    p_d         = p_q;
    pp_d        = pp_q;
    pp_step_d   = pp_step_q;
    pp_vld_d    = 1'b0;
    drain_d     = drain_q;
    accept_c    = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid && !clr) accept_c = 1'b1;
      end
      MUL: begin
        if (!REG_PP) begin
          acc_d = acc_q + pp_place(pp_c, step_q);
          if (step_q == STEP_LAST) begin
            p_d     = acc_d;
            state_d = DONE;
          end else begin
            step_d = step_q + 2'd1;
          end
        end else begin
          if (!drain_q) begin
            pp_d      = pp_c;
            pp_step_d = step_q;
            pp_vld_d  = 1'b1;
            if (step_q == STEP_LAST) drain_d = 1'b1;
            else                     step_d  = step_q + 2'd1;
          end
          if (pp_vld_q) begin
            acc_d = acc_q + pp_place(pp_q, pp_step_q);
            if (pp_step_q == STEP_LAST) begin
              p_d     = acc_d;
              state_d = DONE;
            end
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          if (in_valid && !clr) accept_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept_c) begin
      ops_d    = '{a: a, b: b};
      acc_d    = '0;
      step_d   = '0;
      drain_d  = 1'b0;
      pp_vld_d = 1'b0;
      state_d  = MUL;
    end

    if (clr) begin
      state_d  = IDLE;
      acc_d    = '0;
      step_d   = '0;
      drain_d  = 1'b0;
      pp_vld_d = 1'b0;
    end

    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      step_q      <= '0;
      ops_q       <= '0;
      acc_q       <= '0;
      p_q         <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      pp_q        <= '0;
      pp_step_q   <= '0;
      pp_vld_q    <= 1'b0;
      drain_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      ops_q       <= ops_d;
      acc_q       <= acc_d;
      p_q         <= p_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      pp_q        <= pp_d;
      pp_step_q   <= pp_step_d;
      pp_vld_q    <= pp_vld_d;
      drain_q     <= drain_d;
    end
  end

  assign p         = p_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_dadda_mul16_seq.sv
// Directed and random checks of dadda_mul16_seq in both partial-product register modes.
module tb_dadda_mul16_seq;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        clr0, in_valid0, in_ready0, out_valid0, out_ready0, busy0;
  logic [15:0] a0, b0;
  logic [31:0] p0;

  logic        clr1, in_valid1, in_ready1, out_valid1, out_ready1, busy1;
  logic [15:0] a1, b1;
  logic [31:0] p1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dadda_mul16_seq #(.HALF_W(8), .REG_PP(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr0), .in_valid(in_valid0), .in_ready(in_ready0),
    .a(a0), .b(b0), .out_valid(out_valid0), .out_ready(out_ready0), .p(p0), .busy(busy0)
  );

  dadda_mul16_seq #(.HALF_W(8), .REG_PP(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr1), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(out_ready1), .p(p1), .busy(busy1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op to dut0 from IDLE and wait (bounded) for out_valid
  task automatic issue0(input logic [15:0] av, input logic [15:0] bv,
                        output int lat, output logic [31:0] pv);
    a0 = av;
    b0 = bv;
    in_valid0 = 1'b1;
    tick();
    in_valid0 = 1'b0;
    lat = 0;
    while (lat < 20 && out_valid0 !== 1'b1) begin
      tick();
      lat++;
    end
    pv = p0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clr0 = 1'b0; in_valid0 = 1'b0; out_ready0 = 1'b0; a0 = '0; b0 = '0;
    clr1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({out_valid0, busy0, in_ready0, p0} !== {1'b0, 1'b0, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL reset0: ov=%b busy=%b ir=%b p=%h, expected ov=0 busy=0 ir=1 p=0",
               out_valid0, busy0, in_ready0, p0);
    end
    checks++;
    if ({out_valid1, busy1, in_ready1, p1} !== {1'b0, 1'b0, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL reset1: ov=%b busy=%b ir=%b p=%h, expected ov=0 busy=0 ir=1 p=0",
               out_valid1, busy1, in_ready1, p1);
    end
    rst_n = 1'b1;
    repeat (2) tick();
    checks++;
    if ({out_valid0, busy0, in_ready0} !== 3'b001) begin
      errors++;
      $display("FAIL idle_hold: ov=%b busy=%b ir=%b, expected 0 0 1", out_valid0, busy0, in_ready0);
    end
  endtask

  task automatic test_basic();
    int lat;
    logic [31:0] pv;
    out_ready0 = 1'b1;
    a0 = 16'h1234; b0 = 16'h5678; in_valid0 = 1'b1;
    tick();
    in_valid0 = 1'b0;
    checks++;
    if ({in_ready0, busy0} !== 2'b01) begin
      errors++;
      $display("FAIL basic_mul_ready: in_ready=%b busy=%b, expected 0 1", in_ready0, busy0);
    end
    lat = 0;
    while (lat < 20 && out_valid0 !== 1'b1) begin
      tick();
      lat++;
    end
    pv = p0;
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL basic_latency: got %0d expected 4", lat);
    end
    checks++;
    if (pv !== 32'h06260060) begin
      errors++;
      $display("FAIL basic_p: got %h expected 06260060", pv);
    end
    tick();
    checks++;
    if ({out_valid0, busy0} !== 2'b00) begin
      errors++;
      $display("FAIL basic_release: ov=%b busy=%b expected 0 0", out_valid0, busy0);
    end
  endtask

  task automatic test_corners();
    logic [15:0] av [3] = '{16'hFFFF, 16'h0000, 16'h0100};
    logic [15:0] bv [3] = '{16'hFFFF, 16'hABCD, 16'h0100};
    logic [31:0] ev [3] = '{32'hFFFE0001, 32'h00000000, 32'h00010000};
    int lat;
    logic [31:0] pv;
    out_ready0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue0(av[i], bv[i], lat, pv);
      checks++;
      if (pv !== ev[i] || lat != 4) begin
        errors++;
        $display("FAIL corner%0d: p=%h lat=%0d expected p=%h lat=4", i, pv, lat, ev[i]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] pv;
    logic [31:0] p_hold;
    out_ready0 = 1'b0;
    issue0(16'h00FF, 16'h0101, lat, pv);
    p_hold = p0;
    checks++;
    if (pv !== 32'h0000FFFF || lat != 4) begin
      errors++;
      $display("FAIL bp_first: p=%h lat=%0d expected 0000ffff lat=4", pv, lat);
    end
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++;
      if (out_valid0 !== 1'b1 || p0 !== p_hold) begin
        errors++;
        $display("FAIL bp_hold%0d: ov=%b p=%h expected ov=1 p=%h", i, out_valid0, p0, p_hold);
      end
    end
    out_ready0 = 1'b1;
    in_valid0 = 1'b1; a0 = 16'd3; b0 = 16'd5;
    #1;
    checks++;
    if (in_ready0 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_in_ready: got %b expected 1", in_ready0);
    end
    tick();
    in_valid0 = 1'b0;
    checks++;
    if ({out_valid0, busy0} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_accept: ov=%b busy=%b expected 0 1", out_valid0, busy0);
    end
    lat = 0;
    while (lat < 20 && out_valid0 !== 1'b1) begin
      tick();
      lat++;
    end
    checks++;
    if (p0 !== 32'h0000000F || lat != 4) begin
      errors++;
      $display("FAIL b2b_p: p=%h lat=%0d expected 0000000f lat=4", p0, lat);
    end
    tick();
  endtask

  task automatic test_abort();
    int lat;
    logic [31:0] pv;
    bit never;
    out_ready0 = 1'b1;
    a0 = 16'hFFFF; b0 = 16'h0002; in_valid0 = 1'b1;
    tick();
    in_valid0 = 1'b0;
    repeat (2) tick();
    clr0 = 1'b1;
    tick();
    clr0 = 1'b0;
    checks++;
    if ({busy0, out_valid0, in_ready0, p0} !== {1'b0, 1'b0, 1'b1, 32'h0000000F}) begin
      errors++;
      $display("FAIL abort_idle: busy=%b ov=%b ir=%b p=%h expected 0 0 1 0000000f",
               busy0, out_valid0, in_ready0, p0);
    end
    never = 1'b1;
    repeat (6) begin
      tick();
      if (out_valid0 !== 1'b0) never = 1'b0;
    end
    checks++;
    if (!never) begin
      errors++;
      $display("FAIL abort_no_valid: out_valid rose after clr, expected never");
    end
    clr0 = 1'b1; in_valid0 = 1'b1; a0 = 16'd7; b0 = 16'd7;
    tick();
    clr0 = 1'b0; in_valid0 = 1'b0;
    checks++;
    if (busy0 !== 1'b0) begin
      errors++;
      $display("FAIL clr_beats_valid: busy=%b expected 0", busy0);
    end
    issue0(16'h0010, 16'h0010, lat, pv);
    checks++;
    if (pv !== 32'h00000100 || lat != 4) begin
      errors++;
      $display("FAIL abort_next: p=%h lat=%0d expected 00000100 lat=4", pv, lat);
    end
    tick();
  endtask

  task automatic test_async_reset();
    int lat;
    logic [31:0] pv;
    out_ready0 = 1'b1;
    a0 = 16'h1234; b0 = 16'h5678; in_valid0 = 1'b1;
    tick();
    in_valid0 = 1'b0;
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid0, busy0, in_ready0, p0} !== {1'b0, 1'b0, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL async_reset: ov=%b busy=%b ir=%b p=%h expected 0 0 1 0",
               out_valid0, busy0, in_ready0, p0);
    end
    #1 rst_n = 1'b1;
    tick();
    issue0(16'h00FF, 16'h00FF, lat, pv);
    checks++;
    if (pv !== 32'h0000FE01 || lat != 4) begin
      errors++;
      $display("FAIL async_next: p=%h lat=%0d expected 0000fe01 lat=4", pv, lat);
    end
    tick();
  endtask

  task automatic test_regpp_random();
    localparam int NOPS = 1500;
    logic [31:0] exp_q [$];
    logic [31:0] expv;
    logic [31:0] p_hold;
    int issued;
    int done;
    int cyc;
    int acc_cyc;
    bit ov_prev;
    bit hold;
    bit acc_now;
    bit xfer;
    issued = 0; done = 0; cyc = 0; acc_cyc = 0;
    ov_prev = 1'b0; hold = 1'b0; p_hold = '0;
    in_valid1 = 1'b0; out_ready1 = 1'b0;
    while (done < NOPS && cyc < NOPS * 40) begin
      if (out_valid1 === 1'b1 && !ov_prev) begin
        checks++;
        if (cyc - acc_cyc != 5) begin
          errors++;
          $display("FAIL rand_latency: got %0d expected 5", cyc - acc_cyc);
        end
      end
      if (hold) begin
        checks++;
        if (out_valid1 !== 1'b1 || p1 !== p_hold) begin
          errors++;
          $display("FAIL rand_hold: ov=%b p=%h expected ov=1 p=%h", out_valid1, p1, p_hold);
        end
      end
      ov_prev = (out_valid1 === 1'b1);
      out_ready1 = ($urandom_range(0, 3) != 0);
      if (!in_valid1 && issued < NOPS && $urandom_range(0, 3) != 0) begin
        in_valid1 = 1'b1;
        a1 = 16'($urandom);
        b1 = 16'($urandom);
      end
      #1;
      xfer = (out_valid1 === 1'b1) && out_ready1;
      acc_now = in_valid1 && (in_ready1 === 1'b1);
      if (xfer) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rand_extra: result %h with none outstanding", p1);
        end else begin
          expv = exp_q.pop_front();
          if (p1 !== expv) begin
            errors++;
            $display("FAIL rand_p: got %h expected %h", p1, expv);
          end
        end
        done++;
      end
      if (acc_now) begin
        exp_q.push_back(32'(a1) * 32'(b1));
        issued++;
      end
      hold = (out_valid1 === 1'b1) && !out_ready1;
      p_hold = p1;
      tick();
      cyc++;
      if (acc_now) begin
        acc_cyc = cyc;
        in_valid1 = 1'b0;
      end
    end
    checks++;
    if (done != NOPS || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rand_count: results=%0d pending=%0d expected %0d and 0",
               done, exp_q.size(), NOPS);
    end
    out_ready1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_regpp_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
